// File: rtl/tm1638_pkg.sv
// tm1638_pkg: command bytes and controller state encoding shared by the TM1638 chain controller
package tm1638_pkg;
  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISP_OFF   = 8'h80;
  localparam logic [7:0] CMD_DISP_ON    = 8'h88;
  typedef enum logic [3:0] {
    IDLE, SNAP, DATA_CMD, GAP, ADDR_DATA, CTRL, KEY_CMD, KEY_WAIT, KEY_READ, NEXT
  } state_t;
endpackage

// File: rtl/tm1638_chain_ctrl_if.sv
// tm1638_chain_ctrl_if: shared TM1638 serial bus (CLK, one STB per board, split DIO)
interface tm1638_chain_ctrl_if #(parameter int N_BOARDS = 1);
  logic                tm1638_clk;
  logic [N_BOARDS-1:0] tm1638_stb;
  logic                tm1638_dio_in;
  logic                tm1638_dio_out;
  logic                tm1638_dio_out_en;
  modport master(output tm1638_clk, tm1638_stb, tm1638_dio_out, tm1638_dio_out_en, input tm1638_dio_in);
  modport slave(input tm1638_clk, tm1638_stb, tm1638_dio_out, tm1638_dio_out_en, output tm1638_dio_in);
endinterface

// File: rtl/tm1638_byte_shifter.sv
// tm1638_byte_shifter: one LSB-first byte on TM1638 CLK/DIO; read bytes end at the last rising edge
module tm1638_byte_shifter #(parameter int CLK_DIV = 4) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rd,
  input  logic [7:0] din,
  input  logic       dio_in,
  output logic       sclk,
  output logic       dio,
  output logic       done,
  output logic [7:0] dout
);
  localparam int CW = $clog2(CLK_DIV + 1);
  logic [CW-1:0] cnt;
  logic [2:0] bit_i;
  logic active, high, rd_q;
  wire last = cnt == CW'(CLK_DIV - 1);
  // bit sequencing: CLK low phase with DIO set, then high phase; dout doubles as the shift register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk <= 1'b1; dio <= 1'b1; done <= 1'b0; dout <= '0;
      cnt <= '0; bit_i <= '0; active <= 1'b0; high <= 1'b0; rd_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active <= 1'b1; rd_q <= rd; dout <= din; dio <= din[0];
          sclk <= 1'b0; high <= 1'b0; cnt <= '0; bit_i <= '0;
        end
      end else if (!last) cnt <= cnt + 1'b1;
      else if (!high) begin
        cnt <= '0; high <= 1'b1; sclk <= 1'b1;
        if (rd_q) dout <= {dio_in, dout[7:1]};
        if (rd_q && &bit_i) begin active <= 1'b0; done <= 1'b1; end
      end else if (&bit_i) begin
        active <= 1'b0; done <= 1'b1;
      end else begin
        cnt <= '0; high <= 1'b0; sclk <= 1'b0; bit_i <= bit_i + 1'b1;
        if (!rd_q) begin dout <= {1'b0, dout[7:1]}; dio <= dout[1]; end
      end
    end
endmodule

// File: rtl/tm1638_chain_ctrl.sv
// tm1638_chain_ctrl: refreshes N daisy-strobed TM1638 boards; key scan compiled in with TM1638_KEYS_EN
module tm1638_chain_ctrl
  import tm1638_pkg::*;
#(
  parameter int N_BOARDS  = 1,
  parameter int CLK_DIV   = 4,
  parameter int READ_WAIT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [N_BOARDS*64-1:0] seg_data,
  input  logic [N_BOARDS*8-1:0] leds,
  input  logic [2:0]            brightness,
  input  logic                  display_on,
  output logic [N_BOARDS*8-1:0] keys,
  output logic                  keys_valid,
  output logic                  busy,
  tm1638_chain_ctrl_if.master   bus
);
  localparam int BW = N_BOARDS > 1 ? $clog2(N_BOARDS) : 1;
  localparam logic [BW-1:0] LAST = BW'(N_BOARDS - 1);
  localparam logic [15:0] GAP_END = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] WAIT_END = 16'(READ_WAIT - 1);
  state_t state, state_n, ret, ret_n;
  logic [BW-1:0] board, board_n;
  logic [15:0] cnt;
  logic [4:0] byte_idx, addr;
  logic [2:0] dig;
  logic issued, byte_st, start, rd, done, stb_low;
  logic [7:0] tx, rx;
  logic [63:0] seg_q;
  logic [7:0] led_q;
  logic [2:0] bri_q;
  logic on_q;
  // frame sequencing: which byte/phase comes next and which board follows
  always_comb begin
    state_n = state;
    ret_n = ret;
    board_n = board;
    case (state)
      IDLE:      if (enable) state_n = SNAP;
      SNAP:      state_n = DATA_CMD;
      DATA_CMD:  if (done) begin state_n = GAP; ret_n = ADDR_DATA; end
      ADDR_DATA: if (done && byte_idx == 5'd16) begin state_n = GAP; ret_n = CTRL; end
`ifdef TM1638_KEYS_EN
      CTRL:      if (done) begin state_n = GAP; ret_n = KEY_CMD; end
`else
      CTRL:      if (done) begin state_n = GAP; ret_n = NEXT; end
`endif
      GAP:       if (cnt == GAP_END) state_n = ret;
      KEY_CMD:   if (done) state_n = KEY_WAIT;
      KEY_WAIT:  if (cnt == WAIT_END) state_n = KEY_READ;
      KEY_READ:  if (done && byte_idx == 5'd3) begin state_n = GAP; ret_n = NEXT; end
      NEXT: begin
        board_n = (enable && board != LAST) ? board + 1'b1 : '0;
        state_n = (enable && board != LAST) ? SNAP : IDLE;
      end
      default:   state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // per-state counters, byte issue tracking and the per-board input snapshot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ret <= IDLE; board <= '0; cnt <= '0; byte_idx <= '0; issued <= 1'b0;
      seg_q <= '0; led_q <= '0; bri_q <= '0; on_q <= 1'b0;
    end else begin
      ret <= ret_n;
      board <= board_n;
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      byte_idx <= state_n != state ? '0 : byte_idx + 5'(done);
      issued <= state_n == state && (issued ? !done : start);
      if (state == SNAP) begin
        seg_q <= seg_data[64*board +: 64];
        led_q <= leds[8*board +: 8];
        bri_q <= brightness;
        on_q <= display_on;
      end
    end
  assign byte_st = state inside {DATA_CMD, ADDR_DATA, CTRL, KEY_CMD, KEY_READ};
  assign start = byte_st && !issued;
  assign rd = state == KEY_READ;
  assign addr = byte_idx - 5'd1;
  assign dig = addr[3:1];
  assign tx = state == DATA_CMD ? CMD_WRITE_AUTO :
              state == CTRL     ? (on_q ? (CMD_DISP_ON | {5'b0, bri_q}) : CMD_DISP_OFF) :
              state == KEY_CMD  ? CMD_READ_KEYS :
              state == KEY_READ ? 8'hFF :
              byte_idx == 5'd0  ? CMD_ADDR0 :
              byte_idx[0]       ? seg_q[{dig, 3'b000} +: 8] : {7'b0, led_q[dig]};
  assign stb_low = byte_st || state == KEY_WAIT;
  assign bus.tm1638_stb = stb_low ? ~(N_BOARDS'(1) << board) : '1;
  assign busy = state != IDLE;
  tm1638_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk(clk), .rst_n(rst_n), .start(start), .rd(rd), .din(tx), .dio_in(bus.tm1638_dio_in),
    .sclk(bus.tm1638_clk), .dio(bus.tm1638_dio_out), .done(done), .dout(rx)
  );
`ifdef TM1638_KEYS_EN
  logic [7:0] kacc, kmask;
  // read byte i carries key i in bit0 and key i+4 in bit4
  always_comb begin
    kmask = kacc;
    kmask[byte_idx[1:0]] = rx[0];
    kmask[{1'b1, byte_idx[1:0]}] = rx[4];
  end
  // key mask assembly; the board's mask is published once its last read byte completes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      kacc <= '0; keys <= '0; keys_valid <= 1'b0;
    end else begin
      keys_valid <= 1'b0;
      if (state == KEY_READ && done) begin
        kacc <= kmask;
        if (byte_idx == 5'd3) begin
          keys[8*board +: 8] <= kmask;
          keys_valid <= 1'b1;
        end
      end
    end
  assign bus.tm1638_dio_out_en = !(state inside {KEY_WAIT, KEY_READ});
`else
  assign keys = '0;
  assign keys_valid = 1'b0;
  assign bus.tm1638_dio_out_en = 1'b1;
`endif
endmodule

// File: tb/tb_tm1638_chain_ctrl.sv
// tb_tm1638_chain_ctrl: directed bench with a TM1638 bus model for a three-board chain
module tb_tm1638_chain_ctrl;
  localparam int NB = 3, CD = 2, RW = 8;
`ifdef TM1638_KEYS_EN
  localparam bit KE = 1'b1;
  localparam int L = 20;
`else
  localparam bit KE = 1'b0;
  localparam int L = 19;
`endif
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, display_on = 1'b1;
  logic [2:0] brightness = 3'd7;
  logic [NB*64-1:0] seg_data;
  logic [NB*8-1:0] leds, keys;
  logic keys_valid, busy;
  tm1638_chain_ctrl_if #(.N_BOARDS(NB)) bus();
  tm1638_chain_ctrl #(.N_BOARDS(NB), .CLK_DIV(CD), .READ_WAIT(RW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seg_data(seg_data), .leds(leds),
    .brightness(brightness), .display_on(display_on), .keys(keys), .keys_valid(keys_valid),
    .busy(busy), .bus(bus)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  logic [7:0] lb[$];
  int lbrd[$];
  logic [7:0] resp[3][4];
  int win[3];
  int max_low = 0, oe_bad = 0, oe_low = 0, kv = 0, nb = 0, rcnt = 0, brd = 0;
  logic [7:0] sh = '0;
  logic prev_clk = 1'b1;
  logic [NB-1:0] prev_stb = '1;
  // bus model: captures written bytes per strobed board and answers key reads
  always @(negedge clk) begin
    brd = !bus.tm1638_stb[1] ? 1 : !bus.tm1638_stb[2] ? 2 : 0;
    if ($countones(~bus.tm1638_stb) > max_low) max_low = $countones(~bus.tm1638_stb);
    for (int i = 0; i < NB; i++) if (prev_stb[i] && !bus.tm1638_stb[i]) win[i]++;
    if (!bus.tm1638_dio_out_en) begin
      oe_low++;
      if (&bus.tm1638_stb) oe_bad++;
    end
    if (keys_valid) kv++;
    if (&bus.tm1638_stb) nb = 0;
    else if (bus.tm1638_clk && !prev_clk && bus.tm1638_dio_out_en) begin
      sh = {bus.tm1638_dio_out, sh[7:1]};
      nb++;
      if (nb == 8) begin lb.push_back(sh); lbrd.push_back(brd); nb = 0; end
    end
    if (bus.tm1638_dio_out_en) rcnt = 0;
    else if (bus.tm1638_clk && !prev_clk) rcnt++;
    bus.tm1638_dio_in = rcnt < 32 ? resp[brd][rcnt/8][rcnt%8] : 1'b1;
    prev_clk = bus.tm1638_clk;
    prev_stb = bus.tm1638_stb;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    chk(tag, 32'(busy), 0);
  endtask
  task automatic wait_stb(input int i, input logic lvl, input string tag);
    int n = 0;
    while (bus.tm1638_stb[i] !== lvl && n < 20000) begin @(negedge clk); n++; end
    chk(tag, 32'(bus.tm1638_stb[i]), 32'(lvl));
  endtask
  function automatic int count42(input int from);
    int c = 0;
    for (int i = from; i < lb.size(); i++) if (lb[i] == 8'h42) c++;
    return c;
  endfunction
  initial begin
    int b0, w1, w2, kv0, oe0, n;
    bus.tm1638_dio_in = 1'b1;
    resp[0] = '{8'h01, 8'h00, 8'h10, 8'h00};
    resp[1] = '{8'h00, 8'h01, 8'h00, 8'h10};
    resp[2] = '{8'h10, 8'h10, 8'h10, 8'h10};
    for (int b = 0; b < NB; b++)
      for (int d = 0; d < 8; d++)
        seg_data[b*64+d*8 +: 8] = (b == 0 && d == 0) ? 8'h3F : 8'(b*16 + d + 1);
    leds = {8'h00, 8'h80, 8'h01};
    #12;
    chk("rst_clk", 32'(bus.tm1638_clk), 1);
    chk("rst_stb", 32'(bus.tm1638_stb), 7);
    chk("rst_dio", 32'(bus.tm1638_dio_out), 1);
    chk("rst_oe", 32'(bus.tm1638_dio_out_en), 1);
    chk("rst_keys", 32'(keys), 0);
    chk("rst_kv", 32'(keys_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk) rst_n = 1'b1;
    // full pass over all three boards
    b0 = lb.size(); kv0 = kv; oe0 = oe_low;
    enable = 1'b1;
    wait_stb(2, 1'b0, "p1_reach_b2");
    enable = 1'b0;
    wait_idle("p1_idle");
    chk("p1_nbytes", 32'(lb.size() - b0), 3*L);
    chk("p1_cmd", 32'(lb[b0]), 8'h40);
    chk("p1_addr", 32'(lb[b0+1]), 8'hC0);
    chk("p1_dig0", 32'(lb[b0+2]), 8'h3F);
    chk("p1_led0", 32'(lb[b0+3]), 8'h01);
    chk("p1_dig1", 32'(lb[b0+4]), 8'h02);
    chk("p1_led1", 32'(lb[b0+5]), 8'h00);
    chk("p1_ctrl", 32'(lb[b0+18]), 8'h8F);
    chk("p1_b1_cmd", 32'(lb[b0+L]), 8'h40);
    chk("p1_b1_dig0", 32'(lb[b0+L+2]), 8'h11);
    chk("p1_b1_led7", 32'(lb[b0+L+17]), 8'h01);
    chk("p1_b1_board", 32'(lbrd[b0+L]), 1);
    chk("p1_b2_board", 32'(lbrd[b0+2*L]), 2);
    chk("p1_win0", 32'(win[0]), KE ? 4 : 3);
    chk("p1_win1", 32'(win[1]), KE ? 4 : 3);
    chk("p1_win2", 32'(win[2]), KE ? 4 : 3);
    chk("p1_one_stb", 32'(max_low), 1);
    chk("p1_oe_idle", 32'(oe_bad), 0);
    chk("p1_oe_low", 32'(oe_low - oe0 > 0), 32'(KE));
    chk("p1_n42", 32'(count42(b0)), KE ? 3 : 0);
    chk("p1_keys", 32'(keys), KE ? 24'hF08241 : 24'h0);
    chk("p1_kv", 32'(kv - kv0), KE ? 3 : 0);
    // display off, inputs changed after snapshot, enable dropped during board 0
    b0 = lb.size(); w1 = win[1]; w2 = win[2];
    display_on = 1'b0;
    enable = 1'b1;
    wait_stb(0, 1'b0, "p2_reach_b0");
    brightness = 3'd3;
    display_on = 1'b1;
    enable = 1'b0;
    wait_idle("p2_idle");
    chk("p2_nbytes", 32'(lb.size() - b0), L);
    chk("p2_ctrl", 32'(lb[b0+18]), 8'h80);
    chk("p2_no_b1", 32'(win[1] - w1), 0);
    chk("p2_no_b2", 32'(win[2] - w2), 0);
    // new brightness applies; enable dropped during board 1
    resp[1] = '{8'h00, 8'h00, 8'h00, 8'h01};
    b0 = lb.size(); w2 = win[2];
    enable = 1'b1;
    wait_stb(1, 1'b0, "p3_reach_b1");
    enable = 1'b0;
    wait_idle("p3_idle");
    chk("p3_nbytes", 32'(lb.size() - b0), 2*L);
    chk("p3_ctrl_b0", 32'(lb[b0+18]), 8'h8B);
    chk("p3_ctrl_b1", 32'(lb[b0+L+18]), 8'h8B);
    chk("p3_no_b2", 32'(win[2] - w2), 0);
    chk("p3_keys", 32'(keys), KE ? 24'hF00841 : 24'h0);
    chk("p3_busy", 32'(busy), 0);
    // async reset in the middle of the address/data burst
    enable = 1'b1;
    wait_stb(0, 1'b0, "p4_data_cmd");
    wait_stb(0, 1'b1, "p4_gap");
    wait_stb(0, 1'b0, "p4_addr_data");
    repeat (40) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_stb", 32'(bus.tm1638_stb), 7);
    chk("ar_clk", 32'(bus.tm1638_clk), 1);
    chk("ar_oe", 32'(bus.tm1638_dio_out_en), 1);
    chk("ar_dio", 32'(bus.tm1638_dio_out), 1);
    chk("ar_busy", 32'(busy), 0);
    b0 = lb.size();
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    while (lb.size() == b0 && n < 2000) begin @(negedge clk); n++; end
    chk("ar_first_seen", 32'(lb.size() > b0), 1);
    chk("ar_first_byte", 32'(lb[b0]), 8'h40);
    chk("ar_first_board", 32'(lbrd[b0]), 0);
    enable = 1'b0;
    wait_idle("ar_idle");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
